dp_sequencer: RTL
=================

DP_SEQUENCER -- requirements
Module: dp_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_valid  input  1  instruction offered.
REQ-005 SHALL have port instr  input  10  {we[9], op[8:6], a1[5:4], a2[3:2], a3[1:0]}.
REQ-006 SHALL have port instr_ready  output  1  sequencer can accept an instruction.
REQ-007 SHALL have port ALUControl  output  3  ALU operation to datapath.
REQ-008 SHALL have ports addr1, addr2, addr3  output  2 each  source A, source B, destination register addresses to datapath.
REQ-009 SHALL have port wr  output  1  register-file write strobe to datapath.
REQ-010 SHALL have ports Result  input  32, Zero  input  1, Overflow  input  1  datapath outputs.
REQ-011 SHALL have ports res_valid  output  1, res_ready  input  1, res_data  output  32, res_zero  output  1, res_ovf  output  1  result channel.
REQ-012 SHALL have ports op_count  output  CNT_W, ovf_sticky  output  1.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, WRITE, DONE.
REQ-014 instr_ready SHALL be 1 only in IDLE with rst high; accept = instr_valid && instr_ready.
REQ-015 On accept, SHALL register all instr fields and go IDLE->EXEC; otherwise stay IDLE.
REQ-016 EXEC: ALUControl/addr1/addr2/addr3 driven from registered fields, wr=0; unconditional EXEC->WRITE.
REQ-017 WRITE: fields held, wr=registered we for exactly this one cycle; Result/Zero/Overflow captured into res_data/res_zero/res_ovf at end of cycle; WRITE->DONE.
REQ-018 Captured values SHALL be pre-writeback (same edge as register write).
REQ-019 DONE: res_valid=1, res_* stable; DONE->IDLE when res_ready=1, else hold indefinitely with wr=0.
REQ-020 Latency: accept edge to res_valid high = 3 cycles; minimum issue interval 4 cycles.
REQ-021 Outside EXEC/WRITE, ALUControl/addr* SHALL hold last driven values; wr SHALL be 0 in all states except WRITE.
REQ-022 op_count SHALL increment by 1 on each DONE handshake (res_valid && res_ready), wrapping modulo 2^CNT_W.
REQ-023 instr_valid in non-IDLE states SHALL be ignored; no instruction queued.

Reset
REQ-024 rst low SHALL immediately force IDLE, wr=0, instr_ready=0, res_valid=0, ALUControl=0, addr1..3=0, res_data=0, res_zero=0, res_ovf=0, op_count=0, ovf_sticky=0.
REQ-025 Reset asserted in any state (incl. WRITE) SHALL abort the operation with no further wr pulse and no result delivered.
REQ-026 First accept possible on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro DP_SEQ_STICKY_OVF_EN: defined -> ovf_sticky sets to 1 at the WRITE-capture edge when Overflow=1, cleared only by reset.
REQ-028 Undefined -> ovf_sticky tied 0, no sticky register; all other behaviour identical.

Verification (bench models datapath responses directly)
REQ-029 Accept instr {we=1,op=001,a1=1,a2=1,a3=1}, Result=0, Zero=1 -> wr=1 only on cycle 2 after accept, addr1..3=1; res_valid on cycle 3, res_data=0, res_zero=1.
REQ-030 Accept we=0, op=001, a1=1, a2=3, a3=0, Result=0xFFFFFFFF -> wr never asserts; res_data=0xFFFFFFFF, res_zero=0.
REQ-031 Hold res_ready=0 for 5 cycles in DONE, instr_valid=1 throughout -> res_valid/res_data stable, instr_ready=0, wr=0, op_count unchanged; on release op_count +1.
REQ-032 Assert rst low during WRITE -> wr drops immediately, all outputs at reset values, res_valid never asserts for that instr.
REQ-033 Overflow=1 on op 1, Overflow=0 on op 2 -> with macro ovf_sticky=1 after both; without macro ovf_sticky=0; res_ovf=0 after op 2 either way.
REQ-034 Complete 2^CNT_W handshakes (CNT_W=4: 16 ops) -> op_count returns to 0.

Source files
------------

// File: rtl/dp_sequencer.sv
// Sequencer that issues one instruction at a time to a register-file/ALU datapath and returns its result.
// Optional sticky overflow flag is enabled with `define DP_SEQ_STICKY_OVF_EN.
module dp_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [9:0]       instr,
    output logic             instr_ready,
    output logic [2:0]       ALUControl,
    output logic [1:0]       addr1,
    output logic [1:0]       addr2,
    output logic [1:0]       addr3,
    output logic             wr,
    input  logic [31:0]      Result,
    input  logic             Zero,
    input  logic             Overflow,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_zero,
    output logic             res_ovf,
    output logic [CNT_W-1:0] op_count,
    output logic             ovf_sticky
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       we_p0;
    logic       accept;
    logic       capture;
    logic       handshake;

    // instr_ready also looks at rst directly so it drops the instant reset asserts
    assign instr_ready = (state == IDLE) && rst;
    assign accept      = instr_valid && instr_ready;
    assign capture     = (state == WRITE);
    assign res_valid   = (state == DONE);
    assign handshake   = res_valid && res_ready;
    assign wr          = (state == WRITE) && we_p0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0: instruction fields, held on the datapath until the next accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_p0      <= 1'b0;
            ALUControl <= 3'd0;
            addr1      <= 2'd0;
            addr2      <= 2'd0;
            addr3      <= 2'd0;
        end else if (accept) begin
            we_p0      <= instr[9];
            ALUControl <= instr[8:6];
            addr1      <= instr[5:4];
            addr2      <= instr[3:2];
            addr3      <= instr[1:0];
        end
    end

    // Result stage: sampled on the same edge the register file is written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_data <= 32'd0;
            res_zero <= 1'b0;
            res_ovf  <= 1'b0;
        end else if (capture) begin
            res_data <= Result;
            res_zero <= Zero;
            res_ovf  <= Overflow;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count <= '0;
        end else if (handshake) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

`ifdef DP_SEQ_STICKY_OVF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky <= 1'b0;
        end else if (capture && Overflow) begin
            ovf_sticky <= 1'b1;
        end
    end
`else
    assign ovf_sticky = 1'b0;
`endif

endmodule
